// File: rtl/binario_bcd_seq.sv
// Sequential double-dabble converter: unsigned binary to packed BCD for the digit display.
// One shift-and-add-3 iteration per clock; the result register only changes when done pulses.
module binario_bcd_seq #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binario,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [WIDTH-1:0] bin_r, bin_s;
  logic [BW-1:0]    scr_r, scr_s, adj_s;
  logic             ovf_r, ovf_s;
  logic [CW-1:0]    cnt_r, cnt_s;

  // A nibble of 5..9 becomes 8..12, so a 4-bit add never wraps.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

  // Next-state, add-3 correction and shift datapath.
  always_comb begin
    state_s = state_r;
    bin_s   = bin_r;
    scr_s   = scr_r;
    ovf_s   = ovf_r;
    cnt_s   = cnt_r;
    adj_s   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj_s[4*i +: 4] = add3(scr_r[4*i +: 4]);
    end
    case (state_r)
      IDLE: begin
        if (start) begin
          bin_s   = binario;
          scr_s   = '0;
          ovf_s   = 1'b0;
          cnt_s   = CW'(WIDTH);
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        // The bit leaving the top digit is a multiple of 10^DIGITS: record it, drop it.
        {scr_s, bin_s} = {adj_s[BW-2:0], bin_r, 1'b0};
        ovf_s          = ovf_r | adj_s[BW-1];
        cnt_s          = cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake/result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      bin_r    <= '0;
      scr_r    <= '0;
      ovf_r    <= 1'b0;
      cnt_r    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      state_r <= state_s;
      bin_r   <= bin_s;
      scr_r   <= scr_s;
      ovf_r   <= ovf_s;
      cnt_r   <= cnt_s;
      busy    <= (state_s != IDLE);
      done    <= (state_s == DONE);
      // Result is published on entry to DONE so it is valid in the same cycle as done.
      if ((state_r == SHIFT) && (state_s == DONE)) begin
        bcd      <= scr_s;
        overflow <= ovf_s;
      end
    end
  end

endmodule
